gpac_adc_fifo_arbiter: RTL and testbench

//   Round-robin arbiter merging the 32-bit output FIFOs of up to NUM_CH GPAC ADC receivers

---
 rtl/gpac_adc_fifo_arbiter_if.sv | 29 ++
 rtl/gpac_adc_fifo_arbiter.sv | 132 +++++++++++++
 tb/tb_gpac_adc_fifo_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpac_adc_fifo_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : gpac_adc_fifo_arbiter_if -- upstream FIFO bank + merged stream bus
// Rev    : 1.0
// ============================================================================
interface gpac_adc_fifo_arbiter_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0]    CH_EN;
    logic [NUM_CH-1:0]    CH_FIFO_EMPTY;
    logic [32*NUM_CH-1:0] CH_FIFO_DATA;
    logic [NUM_CH-1:0]    CH_FIFO_READ;
    logic                 FIFO_READ;
    logic                 FIFO_EMPTY;
    logic [31:0]          FIFO_DATA;
    logic [2:0]           GRANT;
    logic                 GRANT_VALID;

    modport master (
        input  CH_EN, CH_FIFO_EMPTY, CH_FIFO_DATA, FIFO_READ,
        output CH_FIFO_READ, FIFO_EMPTY, FIFO_DATA, GRANT, GRANT_VALID
    );

    modport slave (
        output CH_EN, CH_FIFO_EMPTY, CH_FIFO_DATA, FIFO_READ,
        input  CH_FIFO_READ, FIFO_EMPTY, FIFO_DATA, GRANT, GRANT_VALID
    );
endinterface
`default_nettype wire

// File: rtl/gpac_adc_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module : gpac_adc_fifo_arbiter -- round-robin burst merge of ADC receiver FIFOs
// Rev    : 1.0
// ============================================================================
module gpac_adc_fifo_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int MAX_BURST = 256
) (
    input  logic                     BUS_CLK,
    input  logic                     BUS_RST_N,
    gpac_adc_fifo_arbiter_if.master  bus
);
    localparam int             BCW        = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [BCW-1:0] BURST_LAST = (MAX_BURST == 0) ? '0 : BCW'(MAX_BURST - 1);
    localparam logic [2:0]     LAST_RST   = 3'(NUM_CH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t            state_q;
    logic [2:0]        grant_q;
    logic [2:0]        last_q;
    logic [2:0]        grant_d;
    logic              grant_valid_q;
    logic [BCW-1:0]    burst_q;

    logic [NUM_CH-1:0] req;
    logic              any_req;
    logic              sel_en;
    logic              sel_empty;
    logic [31:0]       sel_data;
    logic              out_empty;
    logic              pop;
    logic              burst_end;
    logic              release_gnt;

    assign req     = bus.CH_EN & ~bus.CH_FIFO_EMPTY;
    assign any_req = |req;

    // First requester strictly after the last-served channel, wrapping around.
    always_comb begin : c_rr_pick
        logic       found;
        logic [3:0] idx;
        grant_d = 3'd0;
        found   = 1'b0;
        idx     = 4'd0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = {1'b0, last_q} + 4'(k);
            if (idx >= 4'(NUM_CH)) begin
                idx = idx - 4'(NUM_CH);
            end
            for (int j = 0; j < NUM_CH; j++) begin
                if (!found && (idx == 4'(j)) && req[j]) begin
                    found   = 1'b1;
                    grant_d = 3'(j);
                end
            end
        end
    end

    always_comb begin : c_sel_mux
        sel_en    = 1'b0;
        sel_empty = 1'b1;
        sel_data  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_q == 3'(i)) begin
                sel_en    = bus.CH_EN[i];
                sel_empty = bus.CH_FIFO_EMPTY[i];
                sel_data  = bus.CH_FIFO_DATA[32*i +: 32];
            end
        end
    end

    assign out_empty   = ~grant_valid_q | sel_empty | ~sel_en;
    assign pop         = bus.FIFO_READ & ~out_empty;
    assign burst_end   = (MAX_BURST != 0) && (burst_q == BURST_LAST);
    // A pop only releases on the burst limit; an idle cycle releases once the output is masked.
    assign release_gnt = pop ? burst_end : out_empty;

    always_comb begin : c_up_read
        bus.CH_FIFO_READ = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_q == 3'(i)) begin
                bus.CH_FIFO_READ[i] = pop;
            end
        end
    end

    assign bus.FIFO_EMPTY  = out_empty;
    assign bus.FIFO_DATA   = sel_data;
    assign bus.GRANT       = grant_q;
    assign bus.GRANT_VALID = grant_valid_q;

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            state_q       <= ST_IDLE;
            grant_q       <= 3'd0;
            grant_valid_q <= 1'b0;
            burst_q       <= '0;
            last_q        <= LAST_RST;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        state_q       <= ST_GRANT;
                        grant_q       <= grant_d;
                        grant_valid_q <= 1'b1;
                        burst_q       <= '0;
                    end
                end
                ST_GRANT: begin
                    if (pop) begin
                        burst_q <= burst_q + 1'b1;
                    end
                    if (release_gnt) begin
                        state_q       <= ST_IDLE;
                        grant_valid_q <= 1'b0;
                        last_q        <= grant_q;
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    grant_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_gpac_adc_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_gpac_adc_fifo_arbiter -- directed + random bench with reference model
// Rev    : 1.0
// ============================================================================
module tb_gpac_adc_fifo_arbiter;
    localparam int N  = 4;
    localparam int MB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gpac_adc_fifo_arbiter_if #(.NUM_CH(N)) bus ();

    gpac_adc_fifo_arbiter #(
        .NUM_CH    (N),
        .MAX_BURST (MB)
    ) dut (
        .BUS_CLK   (clk),
        .BUS_RST_N (rst_n),
        .bus       (bus)
    );

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] upq [N][$];
    int          push_seq [N];
    int          cnt_pop [N];
    int          popped_ch [$];
    logic [N-1:0] en_v     = '1;
    logic         rd_v     = 1'b0;
    logic         rst_next = 1'b0;
    logic [N-1:0] last_rd  = '0;
    int           push_pct = 0;
    int           dut_burst = 0;

    // Reference model: who owns the stream, words taken this grant, last channel served
    bit m_busy;
    int m_g, m_cnt, m_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_g    = 0;
        m_cnt  = 0;
        m_last = N - 1;
    endtask

    task automatic push_word(input int ch);
        upq[ch].push_back({8'(ch), 24'(push_seq[ch])});
        push_seq[ch]++;
    endtask

    task automatic drive_inputs();
        bus.CH_EN     = en_v;
        bus.FIFO_READ = rd_v;
        for (int i = 0; i < N; i++) begin
            bus.CH_FIFO_EMPTY[i]       = (upq[i].size() == 0);
            bus.CH_FIFO_DATA[32*i +: 32] = (upq[i].size() != 0) ? upq[i][0] : 32'hBAD0_0000;
        end
    endtask

    task automatic apply_pops();
        for (int i = 0; i < N; i++) begin
            if (last_rd[i] && upq[i].size() != 0) begin
                void'(upq[i].pop_front());
            end
        end
        last_rd = '0;
    endtask

    task automatic step();
        logic         exp_empty, exp_pop, found;
        logic [N-1:0] exp_rd;
        int           c;
        @(negedge clk);
        apply_pops();
        if (push_pct > 0) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(99) < push_pct) push_word(i);
            end
        end
        drive_inputs();
        rst_n = rst_next;
        #1;
        if (!rst_n) begin
            chk("rst_empty", bus.FIFO_EMPTY, 1'b1);
            chk("rst_rd", bus.CH_FIFO_READ, '0);
            chk("rst_gv", bus.GRANT_VALID, 1'b0);
            chk("rst_grant", bus.GRANT, 3'd0);
            last_rd = bus.CH_FIFO_READ;
        end else begin
            exp_rd    = '0;
            exp_empty = 1'b1;
            exp_pop   = 1'b0;
            if (m_busy) begin
                exp_empty = (upq[m_g].size() == 0) || !en_v[m_g];
                exp_pop   = rd_v && !exp_empty;
                if (exp_pop) exp_rd[m_g] = 1'b1;
            end
            chk("grant_valid", bus.GRANT_VALID, m_busy);
            chk("fifo_empty", bus.FIFO_EMPTY, exp_empty);
            chk("ch_fifo_read", bus.CH_FIFO_READ, exp_rd);
            chk("read_onehot", ($countones(bus.CH_FIFO_READ) <= 1), 1'b1);
            if (m_busy) chk("grant", bus.GRANT, 3'(m_g));
            if (!exp_empty) chk("fifo_data", bus.FIFO_DATA, upq[m_g][0]);
            if (!bus.GRANT_VALID) dut_burst = 0;
            for (int i = 0; i < N; i++) begin
                if (bus.CH_FIFO_READ[i]) begin
                    popped_ch.push_back(i);
                    cnt_pop[i]++;
                    dut_burst++;
                    chk("pop_avail", (upq[i].size() != 0), 1'b1);
                    if (upq[i].size() != 0) chk("pop_data", bus.FIFO_DATA, upq[i][0]);
                    chk("burst_le_max", (dut_burst <= MB), 1'b1);
                end
            end
            last_rd = bus.CH_FIFO_READ;
            if (m_busy) begin
                if (exp_pop) m_cnt++;
                if ((exp_pop && m_cnt == MB) || (!exp_pop && exp_empty)) begin
                    m_busy = 1'b0;
                    m_last = m_g;
                end
            end else begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (!found && en_v[c] && upq[c].size() != 0) begin
                        found  = 1'b1;
                        m_busy = 1'b1;
                        m_g    = c;
                        m_cnt  = 0;
                    end
                end
            end
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        apply_pops();
        rd_v = 1'b1;
        drive_inputs();
        #1;
        chk("t1_pre_read", bus.CH_FIFO_READ, 4'b0001);
        #1;
        rst_n    = 1'b0;
        rst_next = 1'b0;
        #1;
        chk("t1_async_empty", bus.FIFO_EMPTY, 1'b1);
        chk("t1_async_rd", bus.CH_FIFO_READ, '0);
        chk("t1_async_gv", bus.GRANT_VALID, 1'b0);
        model_reset();
        dut_burst = 0;
    endtask

    task automatic check_order(input string tag, input int exp_q[$]);
        chk({tag, "_len"}, popped_ch.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < popped_ch.size()) chk(tag, popped_ch[i], exp_q[i]);
        end
    endtask

    initial begin : main
        int guard;
        model_reset();
        for (int i = 0; i < N; i++) begin
            push_seq[i] = 0;
            cnt_pop[i]  = 0;
        end
        drive_inputs();
        repeat (3) step();
        rst_next = 1'b1;

        // Reset with ch0 loaded and granted
        for (int i = 0; i < 3; i++) push_word(0);
        rd_v = 1'b0;
        repeat (3) step();
        async_reset();
        repeat (2) step();
        rst_next = 1'b1;
        popped_ch.delete();
        repeat (8) step();
        check_order("t1_order", '{0, 0, 0});

        // Round robin, one bubble between bursts
        repeat (2) push_word(1);
        repeat (2) push_word(3);
        popped_ch.delete();
        repeat (12) step();
        check_order("t2_order", '{1, 1, 3, 3});

        // Burst limit
        repeat (10) push_word(0);
        push_word(2);
        popped_ch.delete();
        repeat (30) step();
        check_order("t3_order", '{0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0});

        // Disable mid-burst
        repeat (5) push_word(0);
        popped_ch.delete();
        guard = 0;
        while (popped_ch.size() < 2 && guard < 20) begin
            step();
            guard++;
        end
        chk("t4_reach_two_pops", popped_ch.size(), 2);
        en_v[0] = 1'b0;
        repeat (2) push_word(1);
        step();
        chk("t4_mask_empty", bus.FIFO_EMPTY, 1'b1);
        chk("t4_no_third_pop", bus.CH_FIFO_READ, '0);
        repeat (8) step();
        check_order("t4_order", '{0, 0, 1, 1});
        chk("t4_ch0_left", upq[0].size(), 3);
        en_v = '1;
        repeat (12) step();
        chk("t4_ch0_drained", upq[0].size(), 0);

        // Read while empty: idle, then granted channel drained
        repeat (4) step();
        push_word(2);
        popped_ch.delete();
        repeat (6) step();
        check_order("t5_order", '{2});
        chk("t5_ch2_empty", upq[2].size(), 0);

        // Random traffic
        push_pct = 10;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rd_v = ($urandom_range(3) != 0);
            if ($urandom_range(19) == 0) begin
                int ch;
                ch = $urandom_range(N - 1);
                en_v[ch] = ~en_v[ch];
            end
            step();
        end
        push_pct = 0;
        en_v     = '1;
        rd_v     = 1'b1;
        guard    = 0;
        while ((upq[0].size() + upq[1].size() + upq[2].size() + upq[3].size()) != 0 && guard < 3000) begin
            step();
            guard++;
        end
        repeat (4) step();
        for (int i = 0; i < N; i++) begin
            chk("t6_drained", upq[i].size(), 0);
            chk("t6_pop_count", cnt_pop[i], push_seq[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
`default_nettype wire
